// File: rtl/left_rotation_pkg.sv
// Shared types and defaults for the iterative left-rotate block.
package left_rotation_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/left_rotation_1.sv
// Combinational single-position left rotate; the MSB wraps into the LSB.
module left_rotation_1
  import left_rotation_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {din[WIDTH-2:0], din[WIDTH-1]};

endmodule

// File: rtl/left_rotation_n.sv
// Multi-cycle left rotate: rotates dout by one position per clock for
// 'amount' clocks, then pulses done for one cycle.
module left_rotation_n
  import left_rotation_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] rot_out;

  left_rotation_1 #(.WIDTH(WIDTH)) u_rot1 (
    .din  (dout),
    .dout (rot_out)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dout_d  = din;
          count_d = amount;
          state_d = (amount != '0) ? ROTATE : DONE;
        end
      end
      ROTATE: begin
        dout_d  = rot_out;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout    <= dout_d;
    end
  end

  // Status is decoded purely from the state register, so start never reaches it combinationally.
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: doc/left_rotation_n.md
LEFT_ROTATION_N -- requirements
Module: left_rotation_n

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width in bits; legal values are powers of two, 2 to 64.
REQ-002 SHALL have local constant AMT_W = log2(WIDTH), the rotate-amount width (3 when WIDTH=8).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  request to load din/amount and begin rotation.
REQ-006 SHALL have port: din  input  WIDTH  operand, sampled only on an accepted start.
REQ-007 SHALL have port: amount  input  AMT_W  left-rotate distance 0..WIDTH-1, sampled only on an accepted start.
REQ-008 SHALL have port: dout  output  WIDTH  working/result register.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; dout holds the final result while done is high.

Function
REQ-011 SHALL implement FSM states IDLE, ROTATE, DONE.
REQ-012 SHALL accept start only when busy=0; start while busy=1 is ignored, and din/amount are not sampled.
REQ-013 On accepted start: dout<=din; count<=amount; next state ROTATE if amount!=0, else DONE.
REQ-014 In ROTATE, each edge SHALL do dout<={dout[WIDTH-2:0],dout[WIDTH-1]} and count<=count-1; when count==1 before the edge, next state is DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 Latency: done is high after amount+1 rising edges, counting the accepting edge (amount=0 -> 1 edge; amount=7 -> 8 edges).
REQ-017 dout SHALL hold its value in IDLE and DONE, and change only on accepted start or on a ROTATE edge.
REQ-018 Result SHALL equal din rotated left by amount, modulo WIDTH; bits shifted out of the MSB re-enter at the LSB; no bit is lost.
REQ-019 start held high continuously SHALL start a new operation on the first IDLE cycle after each DONE (back-to-back throughput amount+2 cycles).
REQ-020 done and busy SHALL be registered (decoded from state register), with no combinational path from start.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, dout=0, count=0, busy=0, done=0, regardless of clock.
REQ-022 Reset asserted mid-ROTATE SHALL abort the operation; no done pulse is produced for it.
REQ-023 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-024 Shared package left_rotation_pkg SHALL hold the state enum (IDLE, ROTATE, DONE) and the default WIDTH constant.
REQ-025 The single-step rotate SHALL be a combinational sub-module left_rotation_1 (WIDTH-in, WIDTH-out, rotate left by one), instantiated once in the datapath.
REQ-026 The block SHALL contain no other sub-modules; FSM, counter and dout register live in left_rotation_n.

Verification
REQ-027 din=8'b10100001, amount=1, start pulse -> done after 2 edges, dout=8'b01000011.
REQ-028 din=8'b00000001, amount=7 -> done after 8 edges, dout=8'b10000000; busy high for 8 cycles.
REQ-029 din=8'b01111111, amount=3 -> intermediate dout 11111110, 11111101, then result 11111011 with done.
REQ-030 din=8'b10000001, amount=0 -> done after 1 edge, dout=8'b10000001.
REQ-031 Start with din=8'hFF during an amount=5 operation -> ignored; original result unaffected.
REQ-032 rst_n low mid-ROTATE -> dout=0, busy=0 immediately; no done; next start behaves per REQ-027.
